sal_req_dispatcher: RTL and testbench



---
 rtl/sal_req_dispatcher_if.sv | 55 +++++
 rtl/sal_req_dispatcher.sv | 157 +++++++++++++++
 tb/tb_sal_req_dispatcher.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/sal_req_dispatcher_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sal_req_dispatcher_if                                                      |
// | AXI AR/AW address channels in, per-bank request FIFO heads out.            |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface sal_req_dispatcher_if #(
    parameter int BK_CNT     = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int LEN_WIDTH  = 4,
    parameter int RA_WIDTH   = 14,
    parameter int CA_WIDTH   = 10,
    parameter int FIFO_DEPTH = 4
);
    localparam int OCC_WIDTH = $clog2(FIFO_DEPTH) + 1;

    logic                           ar_valid;
    logic                           ar_ready;
    logic [ID_WIDTH-1:0]            ar_id;
    logic [ADDR_WIDTH-1:0]          ar_addr;
    logic [LEN_WIDTH-1:0]           ar_len;

    logic                           aw_valid;
    logic                           aw_ready;
    logic [ID_WIDTH-1:0]            aw_id;
    logic [ADDR_WIDTH-1:0]          aw_addr;
    logic [LEN_WIDTH-1:0]           aw_len;

    logic [BK_CNT-1:0]              bk_valid;
    logic [BK_CNT-1:0]              bk_ready;
    logic [BK_CNT*ID_WIDTH-1:0]     bk_id;
    logic [BK_CNT*RA_WIDTH-1:0]     bk_ra;
    logic [BK_CNT*CA_WIDTH-1:0]     bk_ca;
    logic [BK_CNT*LEN_WIDTH-1:0]    bk_len;
    logic [BK_CNT-1:0]              bk_wr;
    logic [BK_CNT*OCC_WIDTH-1:0]    bk_occ;

    modport master (
        output ar_valid, ar_id, ar_addr, ar_len,
        output aw_valid, aw_id, aw_addr, aw_len,
        output bk_ready,
        input  ar_ready, aw_ready,
        input  bk_valid, bk_id, bk_ra, bk_ca, bk_len, bk_wr, bk_occ
    );

    modport slave (
        input  ar_valid, ar_id, ar_addr, ar_len,
        input  aw_valid, aw_id, aw_addr, aw_len,
        input  bk_ready,
        output ar_ready, aw_ready,
        output bk_valid, bk_id, bk_ra, bk_ca, bk_len, bk_wr, bk_occ
    );
endinterface
`default_nettype wire

// File: rtl/sal_req_dispatcher.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sal_req_dispatcher                                                         |
// | Round-robin AR/AW arbiter, address decode and per-bank request FIFOs.      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module sal_req_dispatcher #(
    parameter int BK_CNT     = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int LEN_WIDTH  = 4,
    parameter int RA_WIDTH   = 14,
    parameter int CA_WIDTH   = 10,
    parameter int OFS_WIDTH  = 3,
    parameter int FIFO_DEPTH = 4,
    parameter int MAP_MODE   = 0
) (
    input wire                  clk,
    input wire                  rst,
    sal_req_dispatcher_if.slave bus
);
    localparam int BA_WIDTH  = $clog2(BK_CNT);
    localparam int PTR_WIDTH = $clog2(FIFO_DEPTH);
    localparam int OCC_WIDTH = PTR_WIDTH + 1;
    localparam int DEC_TOP   = OFS_WIDTH + CA_WIDTH + BA_WIDTH + RA_WIDTH;
    localparam int LEN_LSB   = 1;
    localparam int CA_LSB    = LEN_LSB + LEN_WIDTH;
    localparam int RA_LSB    = CA_LSB + CA_WIDTH;
    localparam int ID_LSB    = RA_LSB + RA_WIDTH;
    localparam int ENT_WIDTH = ID_LSB + ID_WIDTH;
    localparam logic [OCC_WIDTH-1:0] FULL_CNT = OCC_WIDTH'(FIFO_DEPTH);

    logic [BA_WIDTH-1:0]  w_ar_ba, w_aw_ba, w_push_ba;
    logic [RA_WIDTH-1:0]  w_ar_ra, w_aw_ra;
    logic [CA_WIDTH-1:0]  w_ar_ca, w_aw_ca;
    logic [ENT_WIDTH-1:0] w_push_ent;
    logic                 w_ar_elig, w_aw_elig, w_gnt_ar, w_gnt_aw, w_push;
    logic [BK_CNT-1:0]    w_full, w_pop, w_push_bk;
    logic                 w_unused_ofs;

    logic [OCC_WIDTH-1:0] r_cnt  [BK_CNT];
    logic [PTR_WIDTH-1:0] r_wptr [BK_CNT];
    logic [PTR_WIDTH-1:0] r_rptr [BK_CNT];
    logic [ENT_WIDTH-1:0] r_mem  [BK_CNT][FIFO_DEPTH];
    logic                 r_prio_aw;

    // Row sits on top in both mappings; only bank/column order swaps.
    assign w_ar_ra = bus.ar_addr[DEC_TOP-1 -: RA_WIDTH];
    assign w_aw_ra = bus.aw_addr[DEC_TOP-1 -: RA_WIDTH];

    generate
        if (MAP_MODE == 1) begin : g_map_interleave
            assign w_ar_ba = bus.ar_addr[OFS_WIDTH +: BA_WIDTH];
            assign w_ar_ca = bus.ar_addr[OFS_WIDTH+BA_WIDTH +: CA_WIDTH];
            assign w_aw_ba = bus.aw_addr[OFS_WIDTH +: BA_WIDTH];
            assign w_aw_ca = bus.aw_addr[OFS_WIDTH+BA_WIDTH +: CA_WIDTH];
        end else begin : g_map_linear
            assign w_ar_ca = bus.ar_addr[OFS_WIDTH +: CA_WIDTH];
            assign w_ar_ba = bus.ar_addr[OFS_WIDTH+CA_WIDTH +: BA_WIDTH];
            assign w_aw_ca = bus.aw_addr[OFS_WIDTH +: CA_WIDTH];
            assign w_aw_ba = bus.aw_addr[OFS_WIDTH+CA_WIDTH +: BA_WIDTH];
        end

        if (ADDR_WIDTH > DEC_TOP) begin : g_unused_hi
            logic w_unused_hi;
            assign w_unused_hi = ^{bus.ar_addr[ADDR_WIDTH-1:DEC_TOP],
                                   bus.aw_addr[ADDR_WIDTH-1:DEC_TOP]};
        end
    endgenerate

    assign w_unused_ofs = ^{bus.ar_addr[OFS_WIDTH-1:0], bus.aw_addr[OFS_WIDTH-1:0]};

    always_comb begin
        w_full = '0;
        w_pop  = '0;
        for (int i = 0; i < BK_CNT; i++) begin
            w_full[i] = (r_cnt[i] == FULL_CNT);
            w_pop[i]  = (r_cnt[i] != '0) && bus.bk_ready[i];
        end
    end

    // Fullness uses the registered count only, so a same-cycle pop gives no credit.
    assign w_ar_elig = bus.ar_valid && !w_full[w_ar_ba];
    assign w_aw_elig = bus.aw_valid && !w_full[w_aw_ba];
    assign w_gnt_ar  = !rst && w_ar_elig && (!w_aw_elig || !r_prio_aw);
    assign w_gnt_aw  = !rst && w_aw_elig && (!w_ar_elig ||  r_prio_aw);
    assign w_push    = w_gnt_ar || w_gnt_aw;

    assign bus.ar_ready = w_gnt_ar;
    assign bus.aw_ready = w_gnt_aw;

    assign w_push_ba  = w_gnt_aw ? w_aw_ba : w_ar_ba;
    assign w_push_ent = w_gnt_aw ? {bus.aw_id, w_aw_ra, w_aw_ca, bus.aw_len, 1'b1}
                                 : {bus.ar_id, w_ar_ra, w_ar_ca, bus.ar_len, 1'b0};

    always_comb begin
        w_push_bk = '0;
        for (int i = 0; i < BK_CNT; i++) begin
            w_push_bk[i] = w_push && (w_push_ba == BA_WIDTH'(i));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BK_CNT; i++) begin
                r_cnt[i]  <= '0;
                r_wptr[i] <= '0;
                r_rptr[i] <= '0;
            end
            r_prio_aw <= 1'b0;
        end else begin
            for (int i = 0; i < BK_CNT; i++) begin
                if (w_push_bk[i]) begin
                    r_wptr[i] <= r_wptr[i] + 1'b1;
                end
                if (w_pop[i]) begin
                    r_rptr[i] <= r_rptr[i] + 1'b1;
                end
                if (w_push_bk[i] && !w_pop[i]) begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end else if (!w_push_bk[i] && w_pop[i]) begin
                    r_cnt[i] <= r_cnt[i] - 1'b1;
                end
            end
            if (w_ar_elig && w_aw_elig) begin
                r_prio_aw <= !r_prio_aw;
            end
        end
    end

    // Entry storage carries no reset; validity is tracked by the counters.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[w_push_ba][r_wptr[w_push_ba]] <= w_push_ent;
        end
    end

    always_comb begin
        bus.bk_valid = '0;
        bus.bk_id    = '0;
        bus.bk_ra    = '0;
        bus.bk_ca    = '0;
        bus.bk_len   = '0;
        bus.bk_wr    = '0;
        bus.bk_occ   = '0;
        for (int i = 0; i < BK_CNT; i++) begin
            bus.bk_valid[i]                        = (r_cnt[i] != '0);
            bus.bk_id [i*ID_WIDTH  +: ID_WIDTH ]   = r_mem[i][r_rptr[i]][ID_LSB  +: ID_WIDTH ];
            bus.bk_ra [i*RA_WIDTH  +: RA_WIDTH ]   = r_mem[i][r_rptr[i]][RA_LSB  +: RA_WIDTH ];
            bus.bk_ca [i*CA_WIDTH  +: CA_WIDTH ]   = r_mem[i][r_rptr[i]][CA_LSB  +: CA_WIDTH ];
            bus.bk_len[i*LEN_WIDTH +: LEN_WIDTH]   = r_mem[i][r_rptr[i]][LEN_LSB +: LEN_WIDTH];
            bus.bk_wr[i]                           = r_mem[i][r_rptr[i]][0];
            bus.bk_occ[i*OCC_WIDTH +: OCC_WIDTH]   = r_cnt[i];
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_sal_req_dispatcher.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_sal_req_dispatcher                                                      |
// | Directed self-checking bench for both address mapping modes.               |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_sal_req_dispatcher;
    localparam int BK   = 4;
    localparam int AWID = 32;
    localparam int IDW  = 4;
    localparam int LW   = 4;
    localparam int RAW  = 14;
    localparam int CAW  = 10;
    localparam int DEP  = 4;
    localparam int OCCW = 3;

    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    sal_req_dispatcher_if #(.BK_CNT(BK), .ADDR_WIDTH(AWID), .ID_WIDTH(IDW), .LEN_WIDTH(LW),
                            .RA_WIDTH(RAW), .CA_WIDTH(CAW), .FIFO_DEPTH(DEP)) bus0 ();
    sal_req_dispatcher_if #(.BK_CNT(BK), .ADDR_WIDTH(AWID), .ID_WIDTH(IDW), .LEN_WIDTH(LW),
                            .RA_WIDTH(RAW), .CA_WIDTH(CAW), .FIFO_DEPTH(DEP)) bus1 ();

    sal_req_dispatcher #(.BK_CNT(BK), .ADDR_WIDTH(AWID), .ID_WIDTH(IDW), .LEN_WIDTH(LW),
                         .RA_WIDTH(RAW), .CA_WIDTH(CAW), .OFS_WIDTH(3), .FIFO_DEPTH(DEP),
                         .MAP_MODE(0)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
    sal_req_dispatcher #(.BK_CNT(BK), .ADDR_WIDTH(AWID), .ID_WIDTH(IDW), .LEN_WIDTH(LW),
                         .RA_WIDTH(RAW), .CA_WIDTH(CAW), .OFS_WIDTH(3), .FIFO_DEPTH(DEP),
                         .MAP_MODE(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic chk_head(input string tag, input int b,
                            input logic [BK*IDW-1:0] f_id, input logic [BK*RAW-1:0] f_ra,
                            input logic [BK*CAW-1:0] f_ca, input logic [BK*LW-1:0] f_len,
                            input logic [BK-1:0] f_wr,
                            input logic [IDW-1:0] e_id, input logic [RAW-1:0] e_ra,
                            input logic [CAW-1:0] e_ca, input logic [LW-1:0] e_len,
                            input logic e_wr);
        chk({tag, "_id"},  64'(f_id [b*IDW +: IDW]), 64'(e_id));
        chk({tag, "_ra"},  64'(f_ra [b*RAW +: RAW]), 64'(e_ra));
        chk({tag, "_ca"},  64'(f_ca [b*CAW +: CAW]), 64'(e_ca));
        chk({tag, "_len"}, 64'(f_len[b*LW  +: LW ]), 64'(e_len));
        chk({tag, "_wr"},  64'(f_wr[b]),             64'(e_wr));
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic set_ar(input logic v, input logic [AWID-1:0] a, input logic [IDW-1:0] id,
                          input logic [LW-1:0] len);
        bus0.ar_valid = v;
        bus0.ar_addr  = a;
        bus0.ar_id    = id;
        bus0.ar_len   = len;
    endtask

    task automatic set_aw(input logic v, input logic [AWID-1:0] a, input logic [IDW-1:0] id,
                          input logic [LW-1:0] len);
        bus0.aw_valid = v;
        bus0.aw_addr  = a;
        bus0.aw_id    = id;
        bus0.aw_len   = len;
    endtask

    initial begin
        rst = 1'b1;
        set_ar(1'b0, '0, '0, '0);
        set_aw(1'b0, '0, '0, '0);
        bus0.bk_ready = '0;
        bus1.ar_valid = 1'b0; bus1.ar_addr = '0; bus1.ar_id = '0; bus1.ar_len = '0;
        bus1.aw_valid = 1'b0; bus1.aw_addr = '0; bus1.aw_id = '0; bus1.aw_len = '0;
        bus1.bk_ready = '0;

        // Reset state, ready held low even with a request pending
        set_ar(1'b1, 32'h0, 4'd0, 4'd0);
        mid();
        chk("rst_ar_ready", 64'(bus0.ar_ready), 64'd0);
        chk("rst_bk_valid", 64'(bus0.bk_valid), 64'd0);
        chk("rst_bk_occ",   64'(bus0.bk_occ),   64'd0);
        set_ar(1'b0, '0, '0, '0);
        cyc();
        rst = 1'b0;

        // Decode in both mapping modes
        set_ar(1'b1, 32'h0001_6008, 4'd5, 4'd3);
        bus1.aw_valid = 1'b1; bus1.aw_addr = 32'h0001_6008; bus1.aw_id = 4'd9; bus1.aw_len = 4'd3;
        mid();
        chk("dec0_ar_ready", 64'(bus0.ar_ready), 64'd1);
        chk("dec1_aw_ready", 64'(bus1.aw_ready), 64'd1);
        cyc();
        set_ar(1'b0, '0, '0, '0);
        bus1.aw_valid = 1'b0;
        mid();
        chk("dec0_valid", 64'(bus0.bk_valid), 64'b1000);
        chk("dec0_occ3",  64'(bus0.bk_occ[3*OCCW +: OCCW]), 64'd1);
        chk_head("dec0", 3, bus0.bk_id, bus0.bk_ra, bus0.bk_ca, bus0.bk_len, bus0.bk_wr,
                 4'd5, 14'd2, 10'h001, 4'd3, 1'b0);
        chk("dec1_valid", 64'(bus1.bk_valid), 64'b0010);
        chk_head("dec1", 1, bus1.bk_id, bus1.bk_ra, bus1.bk_ca, bus1.bk_len, bus1.bk_wr,
                 4'd9, 14'd2, 10'h300, 4'd3, 1'b1);
        bus0.bk_ready = '1;
        bus1.bk_ready = '1;
        cyc();
        mid();
        chk("dec0_drained", 64'(bus0.bk_valid), 64'd0);
        chk("dec1_drained", 64'(bus1.bk_valid), 64'd0);

        // Contention: AR to bank 0, AW to bank 1, banks draining
        cyc();
        set_ar(1'b1, 32'h0000_0000, 4'd1, 4'd0);
        set_aw(1'b1, 32'h0000_2000, 4'd2, 4'd0);
        for (int k = 0; k < 4; k++) begin
            mid();
            chk("contend_grant", 64'({bus0.ar_ready, bus0.aw_ready}),
                (k % 2 == 0) ? 64'b10 : 64'b01);
            cyc();
        end
        set_ar(1'b0, '0, '0, '0);
        set_aw(1'b0, '0, '0, '0);
        cyc();
        mid();
        chk("contend_drained", 64'(bus0.bk_occ), 64'd0);

        // Full bank 0: fifth request waits for a pop
        cyc();
        bus0.bk_ready = '0;
        for (int k = 0; k < 4; k++) begin
            set_ar(1'b1, 32'h0, 4'(k + 1), 4'd0);
            cyc();
        end
        set_ar(1'b1, 32'h0, 4'd5, 4'd0);
        mid();
        chk("full_ready", 64'(bus0.ar_ready), 64'd0);
        chk("full_occ0",  64'(bus0.bk_occ[0 +: OCCW]), 64'd4);
        cyc();
        mid();
        chk("full_ready_hold", 64'(bus0.ar_ready), 64'd0);
        bus0.bk_ready = 4'b0001;
        #1;
        chk("full_no_pop_credit", 64'(bus0.ar_ready), 64'd0);
        chk("full_head_first", 64'(bus0.bk_id[0 +: IDW]), 64'd1);
        cyc();
        bus0.bk_ready = '0;
        mid();
        chk("full_after_pop_ready", 64'(bus0.ar_ready), 64'd1);
        chk("full_after_pop_occ",   64'(bus0.bk_occ[0 +: OCCW]), 64'd3);
        cyc();
        set_ar(1'b0, '0, '0, '0);
        bus0.bk_ready = 4'b0001;
        for (int k = 2; k <= 5; k++) begin
            mid();
            chk("full_order", 64'(bus0.bk_id[0 +: IDW]), 64'(k));
            cyc();
        end
        mid();
        chk("full_drained", 64'(bus0.bk_valid[0]), 64'd0);

        // Blocking isolation: bank 0 full, AW to bank 2 keeps flowing
        cyc();
        bus0.bk_ready = '0;
        for (int k = 0; k < 4; k++) begin
            set_ar(1'b1, 32'h0, 4'(k), 4'd0);
            cyc();
        end
        set_ar(1'b1, 32'h0, 4'd7, 4'd0);
        set_aw(1'b1, 32'h0000_4000, 4'd3, 4'd1);
        for (int k = 0; k < 3; k++) begin
            mid();
            chk("iso_grant", 64'({bus0.ar_ready, bus0.aw_ready}), 64'b01);
            cyc();
        end
        set_ar(1'b0, '0, '0, '0);
        set_aw(1'b0, '0, '0, '0);
        mid();
        chk("iso_occ0", 64'(bus0.bk_occ[0 +: OCCW]), 64'd4);
        chk("iso_occ2", 64'(bus0.bk_occ[2*OCCW +: OCCW]), 64'd3);

        // Pointer moves to AW on a contended grant, reset restores AR
        set_ar(1'b1, 32'h0000_2000, 4'd1, 4'd0);
        set_aw(1'b1, 32'h0000_6000, 4'd2, 4'd0);
        #1;
        chk("prio_first_ar", 64'({bus0.ar_ready, bus0.aw_ready}), 64'b10);
        cyc();
        chk("prio_then_aw", 64'({bus0.ar_ready, bus0.aw_ready}), 64'b01);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 64'(bus0.bk_valid), 64'd0);
        chk("mid_rst_occ",   64'(bus0.bk_occ),   64'd0);
        chk("mid_rst_ready", 64'({bus0.ar_ready, bus0.aw_ready}), 64'b00);
        cyc();
        rst = 1'b0;
        #1;
        chk("rst_prio_ar", 64'({bus0.ar_ready, bus0.aw_ready}), 64'b10);
        cyc();
        set_ar(1'b0, '0, '0, '0);
        set_aw(1'b0, '0, '0, '0);
        mid();
        chk("post_rst_valid", 64'(bus0.bk_valid), 64'b0010);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
